// File: rtl/unit_prop_ctrl_if.sv
// Handshake bundle between the unit-propagation sequencer and the shared
// unit-clause finder / clause simplifier datapaths.
interface unit_prop_ctrl_if #(
    parameter int FORM_W = 32,
    parameter int LIT_W  = 8
);
    logic              uc_find;
    logic [FORM_W-1:0] uc_formula;
    logic              uc_ended;
    logic              uc_found;
    logic [LIT_W-1:0]  uc_lit;
    logic              simp_start;
    logic [LIT_W-1:0]  simp_lit;
    logic              simp_done;
    logic [FORM_W-1:0] simp_formula;
    logic              simp_conflict;
    logic              simp_sat;

    modport master (
        output uc_find, uc_formula, simp_start, simp_lit,
        input  uc_ended, uc_found, uc_lit, simp_done, simp_formula, simp_conflict, simp_sat
    );
    modport slave (
        input  uc_find, uc_formula, simp_start, simp_lit,
        output uc_ended, uc_found, uc_lit, simp_done, simp_formula, simp_conflict, simp_sat
    );
endinterface

// File: rtl/unit_prop_ctrl.sv
// Unit-propagation sequencer: alternates finder and simplifier until the formula
// is stable, conflicting, satisfied or the propagation limit is hit; logs each literal.
module unit_prop_ctrl #(
    parameter int MAX_PROPS = 64,
    parameter int CNT_W     = 7,
    parameter int FORM_W    = 32,
    parameter int LIT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [FORM_W-1:0] in_formula,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [FORM_W-1:0] out_formula,
    output logic [CNT_W-1:0]  prop_count,
    unit_prop_ctrl_if.master  dp,
    output logic              trail_we,
    output logic [CNT_W-1:0]  trail_idx,
    output logic [LIT_W-1:0]  trail_lit
);
    typedef enum logic [2:0] {IDLE, FIND, FIND_WAIT, SIMP_WAIT, DONE} state_e;
    typedef enum logic [1:0] {ST_STABLE, ST_CONFLICT, ST_SAT, ST_OVERFLOW} status_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PROPS);

    state_e            state, state_nxt;
    logic [1:0]        status_nxt;
    logic [CNT_W-1:0]  count_nxt, tidx_nxt;
    logic [LIT_W-1:0]  tlit_nxt, slit_nxt, slit_q;
    logic [FORM_W-1:0] form_nxt, form_q;
    logic              find_nxt, find_q, sstart_nxt, sstart_q, twe_nxt;

    assign out_formula   = form_q;
    assign dp.uc_formula = form_q;
    assign dp.uc_find    = find_q;
    assign dp.simp_start = sstart_q;
    assign dp.simp_lit   = slit_q;

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        count_nxt  = prop_count;
        form_nxt   = form_q;
        slit_nxt   = slit_q;
        tidx_nxt   = trail_idx;
        tlit_nxt   = trail_lit;
        find_nxt   = 1'b0;
        sstart_nxt = 1'b0;
        twe_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = FIND;
                    form_nxt   = in_formula;
                    count_nxt  = '0;
                    status_nxt = ST_STABLE;
                    find_nxt   = 1'b1;
                end
            end
            // Entered from SIMP_WAIT with find low: spend one cycle on the freshly
            // loaded formula, then pulse find and move on once it has been issued.
            FIND: begin
                if (find_q) state_nxt = FIND_WAIT;
                else        find_nxt  = 1'b1;
            end
            FIND_WAIT: begin
                if (dp.uc_ended) begin
                    if (dp.uc_found) begin
                        state_nxt  = SIMP_WAIT;
                        slit_nxt   = dp.uc_lit;
                        tidx_nxt   = prop_count;
                        tlit_nxt   = dp.uc_lit;
                        twe_nxt    = 1'b1;
                        sstart_nxt = 1'b1;
                        if (prop_count != MAX_CNT) count_nxt = prop_count + CNT_W'(1);
                    end else begin
                        state_nxt  = DONE;
                        status_nxt = ST_STABLE;
                    end
                end
            end
            SIMP_WAIT: begin
                if (dp.simp_done) begin
                    form_nxt = dp.simp_formula;
                    if (dp.simp_conflict) begin
                        state_nxt  = DONE;
                        status_nxt = ST_CONFLICT;
                    end else if (dp.simp_sat) begin
                        state_nxt  = DONE;
                        status_nxt = ST_SAT;
                    end else if (prop_count == MAX_CNT) begin
                        state_nxt  = DONE;
                        status_nxt = ST_OVERFLOW;
                    end else begin
                        state_nxt  = FIND;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            find_q     <= 1'b0;
            sstart_q   <= 1'b0;
            trail_we   <= 1'b0;
            status     <= ST_STABLE;
            prop_count <= '0;
            trail_idx  <= '0;
            trail_lit  <= '0;
            form_q     <= '0;
            slit_q     <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == FIND) || (state_nxt == FIND_WAIT) || (state_nxt == SIMP_WAIT);
            done       <= (state_nxt == DONE);
            find_q     <= find_nxt;
            sstart_q   <= sstart_nxt;
            trail_we   <= twe_nxt;
            status     <= status_nxt;
            prop_count <= count_nxt;
            trail_idx  <= tidx_nxt;
            trail_lit  <= tlit_nxt;
            form_q     <= form_nxt;
            slit_q     <= slit_nxt;
        end
    end
endmodule
